mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 21 ++
 rtl/mem_access_unit_if.sv | 16 +
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit.
//   DEF_INTERNAL_BITS : default datapath width
//   state_t           : access FSM encoding (IDLE / ACCESS / ERR)
//   ctl_t             : control fields latched alongside a memory request
package mem_access_unit_pkg;

  localparam int DEF_INTERNAL_BITS = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ERR    = 2'd2
  } state_t;

  typedef struct packed {
    logic       we;   // 1 = store, 0 = load
    logic [1:0] wb;   // {reg write, mem to reg}
    logic [4:0] rd;   // destination register
  } ctl_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory (slave).
//   req/we/addr/wdata : request, held stable by the master until ack
//   ack/rdata         : completion strobe and read data from memory
interface mem_access_unit_if #(
  parameter int W = 32
);
  logic         req;
  logic         we;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic         ack;
  logic [W-1:0] rdata;

  modport master (output req, we, addr, wdata, input  ack, rdata);
  modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues word-aligned loads/stores to data memory, stalls
// the upstream pipe while waiting for ack, times out into a sticky error state,
// and presents registered MEM/WB fields.
// Ports:
//   clk, rst            : clock, async active-high reset
//   valid_in .. reg_dst_in : EX/MEM pipeline register fields
//   dm                  : data-memory bus (master side)
//   stall               : freeze EX/MEM and earlier stages
//   branch_taken/target : branch resolution (combinational)
//   valid_out .. reg_dst_out : MEM/WB fields (registered)
//   misalign_err        : one-cycle pulse on misaligned access
//   bus_err             : sticky, set on ack timeout
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int INTERNAL_BITS = DEF_INTERNAL_BITS,
  parameter int TIMEOUT       = 16    // 2..255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [1:0]               wb_in,
  input  logic [2:0]               m_in,
  input  logic [INTERNAL_BITS-1:0] alu_result_in,
  input  logic [INTERNAL_BITS-1:0] alu_src2_in,
  input  logic                     alu_zero_in,
  input  logic [INTERNAL_BITS-1:0] pc_in,
  input  logic [4:0]               reg_dst_in,
  mem_access_unit_if.master        dm,
  output logic                     stall,
  output logic                     branch_taken,
  output logic [INTERNAL_BITS-1:0] branch_target,
  output logic                     valid_out,
  output logic [1:0]               wb_out,
  output logic [INTERNAL_BITS-1:0] mem_rdata_out,
  output logic [INTERNAL_BITS-1:0] alu_result_out,
  output logic [4:0]               reg_dst_out,
  output logic                     misalign_err,
  output logic                     bus_err
);

  state_t                   state, state_nxt;
  logic [7:0]               wait_cnt;
  logic [INTERNAL_BITS-1:0] cap_addr, cap_wdata;
  ctl_t                     cap_ctl;
  logic                     req_c, stall_c;

  // mem read + mem write together is a store; only the write bit matters
  wire is_acc  = valid_in & (m_in[1] | m_in[0]);
  wire aligned = (alu_result_in[1:0] == 2'b00);
  wire go      = is_acc & aligned;
  wire mis     = is_acc & ~aligned;
  wire timeout = (wait_cnt == 8'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;

  // next state; ERR is left only through reset
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go) state_nxt = S_ACCESS;
      S_ACCESS: if (dm.ack)       state_nxt = S_IDLE;
                else if (timeout) state_nxt = S_ERR;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; the ack cycle itself releases the stall so EX/MEM advances
  always_comb begin
    req_c   = 1'b0;
    stall_c = 1'b0;
    case (state)
      S_IDLE:   stall_c = go;
      S_ACCESS: begin req_c = 1'b1; stall_c = ~dm.ack; end
      S_ERR:    stall_c = 1'b1;
      default:  ;
    endcase
  end

  // combinational outputs are masked by rst so they read 0 during reset
  assign dm.req        = req_c & ~rst;
  assign dm.we         = cap_ctl.we;
  assign dm.addr       = cap_addr;
  assign dm.wdata      = cap_wdata;
  assign stall         = stall_c & ~rst;
  assign branch_taken  = valid_in & m_in[2] & alu_zero_in & ~stall & ~rst;
  assign branch_target = rst ? '0 : pc_in;

  // capture registers, wait counter, MEM/WB outputs, error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt       <= '0;
      cap_addr       <= '0;
      cap_wdata      <= '0;
      cap_ctl        <= '0;
      valid_out      <= 1'b0;
      wb_out         <= '0;
      mem_rdata_out  <= '0;
      alu_result_out <= '0;
      reg_dst_out    <= '0;
      misalign_err   <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      // default: bubble; remaining MEM/WB fields hold
      valid_out    <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;   // every ACCESS entry starts from zero
          if (go) begin
            cap_addr   <= alu_result_in;
            cap_wdata  <= alu_src2_in;
            cap_ctl.we <= m_in[0];
            cap_ctl.wb <= wb_in;
            cap_ctl.rd <= reg_dst_in;
          end else if (valid_in) begin
            // non-access or misaligned: pass straight through, no memory op
            valid_out      <= 1'b1;
            wb_out         <= mis ? {1'b0, wb_in[0]} : wb_in;
            alu_result_out <= alu_result_in;
            reg_dst_out    <= reg_dst_in;
            mem_rdata_out  <= '0;
            misalign_err   <= mis;
          end
        end
        S_ACCESS: begin
          if (dm.ack) begin
            valid_out      <= 1'b1;
            wb_out         <= cap_ctl.wb;
            alu_result_out <= cap_addr;
            reg_dst_out    <= cap_ctl.rd;
            mem_rdata_out  <= cap_ctl.we ? '0 : dm.rdata;
          end else if (timeout) begin
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_ERR:   bus_err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [31:0] alu_result_in, alu_src2_in, pc_in;
  logic        alu_zero_in;
  logic [4:0]  reg_dst_in;
  logic        stall, branch_taken, valid_out, misalign_err, bus_err;
  logic [31:0] branch_target, mem_rdata_out, alu_result_out;
  logic [1:0]  wb_out;
  logic [4:0]  reg_dst_out;

  always #5 clk = ~clk;

  mem_access_unit_if #(.W(32)) dm_if ();

  mem_access_unit #(.INTERNAL_BITS(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .wb_in(wb_in), .m_in(m_in),
    .alu_result_in(alu_result_in), .alu_src2_in(alu_src2_in),
    .alu_zero_in(alu_zero_in), .pc_in(pc_in), .reg_dst_in(reg_dst_in),
    .dm(dm_if), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .valid_out(valid_out), .wb_out(wb_out),
    .mem_rdata_out(mem_rdata_out), .alu_result_out(alu_result_out),
    .reg_dst_out(reg_dst_out), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [2:0] m, input logic [1:0] wb,
                     input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    valid_in = v; m_in = m; wb_in = wb;
    alu_result_in = a; alu_src2_in = d; reg_dst_in = rd;
  endtask

  int sc, n;

  initial begin
    rst = 1'b1;
    drv(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 5'd0);
    alu_zero_in = 1'b0; pc_in = 32'h0;
    dm_if.ack = 1'b0; dm_if.rdata = 32'h0;
    #12;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_bus_err",   32'(bus_err),   32'd0);
    chk("rst_req",       32'(dm_if.req), 32'd0);
    chk("rst_alu_out",   alu_result_out, 32'h0);
    // an aligned access presented during reset must not stall
    drv(1'b1, 3'b010, 2'b11, 32'h100, 32'h0, 5'd1);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    drv(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 5'd0);
    @(negedge clk); rst = 1'b0;
    tick;

    // R-type pass-through
    drv(1'b1, 3'b000, 2'b10, 32'h55, 32'h0, 5'd3);
    #1;
    chk("rtype_stall", 32'(stall), 32'd0);
    chk("rtype_req",   32'(dm_if.req), 32'd0);
    tick;
    chk("rtype_valid", 32'(valid_out), 32'd1);
    chk("rtype_alu",   alu_result_out, 32'h55);
    chk("rtype_wb",    32'(wb_out), 32'd2);
    chk("rtype_rd",    32'(reg_dst_out), 32'd3);
    chk("rtype_rdata", mem_rdata_out, 32'h0);
    drv(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 5'd0);
    tick;
    chk("bubble_valid", 32'(valid_out), 32'd0);
    chk("bubble_hold",  alu_result_out, 32'h55);

    // load 0x100, ack on third ACCESS cycle
    sc = 0;
    drv(1'b1, 3'b010, 2'b11, 32'h100, 32'h0, 5'd5);
    #1; if (stall) sc++;
    chk("ld_idle_req", 32'(dm_if.req), 32'd0);
    tick;
    chk("ld_req",  32'(dm_if.req), 32'd1);
    chk("ld_addr", dm_if.addr, 32'h100);
    chk("ld_we",   32'(dm_if.we), 32'd0);
    if (stall) sc++;
    tick;
    if (stall) sc++;
    chk("ld_wait_valid", 32'(valid_out), 32'd0);
    tick;
    dm_if.ack = 1'b1; dm_if.rdata = 32'hDEADBEEF;
    #1; if (stall) sc++;
    chk("ld_stall_cycles", 32'(sc), 32'd3);
    tick;
    dm_if.ack = 1'b0; valid_in = 1'b0;
    chk("ld_valid", 32'(valid_out), 32'd1);
    chk("ld_rdata", mem_rdata_out, 32'hDEADBEEF);
    chk("ld_wb",    32'(wb_out), 32'd3);
    chk("ld_rd",    32'(reg_dst_out), 32'd5);
    chk("ld_alu",   alu_result_out, 32'h100);
    #1;
    chk("ld_done_req", 32'(dm_if.req), 32'd0);
    tick;
    chk("ld_after_valid", 32'(valid_out), 32'd0);
    chk("ld_after_hold",  mem_rdata_out, 32'hDEADBEEF);

    // store 0x24 (read+write bits both set => write), ack with first request
    drv(1'b1, 3'b011, 2'b00, 32'h24, 32'h12345678, 5'd0);
    #1;
    chk("st_idle_stall", 32'(stall), 32'd1);
    tick;
    dm_if.ack = 1'b1; dm_if.rdata = 32'hFFFFFFFF;
    #1;
    chk("st_req",   32'(dm_if.req), 32'd1);
    chk("st_we",    32'(dm_if.we), 32'd1);
    chk("st_addr",  dm_if.addr, 32'h24);
    chk("st_wdata", dm_if.wdata, 32'h12345678);
    chk("st_stall", 32'(stall), 32'd0);
    tick;
    dm_if.ack = 1'b0; valid_in = 1'b0;
    chk("st_valid", 32'(valid_out), 32'd1);
    chk("st_rdata", mem_rdata_out, 32'h0);

    // ack while IDLE is ignored
    dm_if.ack = 1'b1;
    tick;
    dm_if.ack = 1'b0;
    chk("idle_ack_valid", 32'(valid_out), 32'd0);

    // misaligned load
    drv(1'b1, 3'b010, 2'b11, 32'h102, 32'h0, 5'd9);
    #1;
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_req",   32'(dm_if.req), 32'd0);
    tick;
    valid_in = 1'b0;
    chk("mis_err",   32'(misalign_err), 32'd1);
    chk("mis_valid", 32'(valid_out), 32'd1);
    chk("mis_wb",    32'(wb_out), 32'd1);
    chk("mis_req2",  32'(dm_if.req), 32'd0);
    tick;
    chk("mis_pulse", 32'(misalign_err), 32'd0);

    // branch
    drv(1'b1, 3'b100, 2'b00, 32'h0, 32'h0, 5'd0);
    alu_zero_in = 1'b1; pc_in = 32'h40;
    #1;
    chk("br_taken",  32'(branch_taken), 32'd1);
    chk("br_target", branch_target, 32'h40);
    alu_zero_in = 1'b0;
    #1;
    chk("br_not_taken", 32'(branch_taken), 32'd0);
    tick;
    valid_in = 1'b0;

    // ack on the last allowed cycle (counter at TIMEOUT-1) is a success
    drv(1'b1, 3'b010, 2'b10, 32'h200, 32'h0, 5'd7);
    tick;
    for (int i = 0; i < 15; i++) tick;
    dm_if.ack = 1'b1; dm_if.rdata = 32'hCAFEF00D;
    #1;
    chk("edge_req",   32'(dm_if.req), 32'd1);
    chk("edge_stall", 32'(stall), 32'd0);
    tick;
    dm_if.ack = 1'b0; valid_in = 1'b0;
    chk("edge_valid", 32'(valid_out), 32'd1);
    chk("edge_rdata", mem_rdata_out, 32'hCAFEF00D);
    chk("edge_buserr", 32'(bus_err), 32'd0);

    // timeout: no ack ever
    drv(1'b1, 3'b010, 2'b11, 32'h300, 32'h0, 5'd4);
    tick;
    n = 0;
    while (dm_if.req === 1'b1 && n < 40) begin
      n++;
      tick;
    end
    chk("to_access_cycles", 32'(n), 32'd16);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_stall",   32'(stall), 32'd1);
    chk("to_req",     32'(dm_if.req), 32'd0);
    chk("to_valid",   32'(valid_out), 32'd0);
    dm_if.ack = 1'b1;
    tick;
    dm_if.ack = 1'b0;
    chk("err_sticky", 32'(bus_err), 32'd1);
    chk("err_stall",  32'(stall), 32'd1);

    // reset out of ERR
    rst = 1'b1;
    #1;
    chk("rerr_bus_err", 32'(bus_err), 32'd0);
    chk("rerr_stall",   32'(stall), 32'd0);
    chk("rerr_rdata",   mem_rdata_out, 32'h0);
    chk("rerr_alu",     alu_result_out, 32'h0);
    chk("rerr_wb",      32'(wb_out), 32'd0);
    chk("rerr_addr",    dm_if.addr, 32'h0);
    @(negedge clk); rst = 1'b0;
    tick;
    chk("rerr_reenter_req", 32'(dm_if.req), 32'd1);
    // reset mid-access drops the request at once
    #2; rst = 1'b1;
    #1;
    chk("rmid_req", 32'(dm_if.req), 32'd0);
    valid_in = 1'b0;
    @(negedge clk); rst = 1'b0;
    tick;
    chk("rmid_idle_req", 32'(dm_if.req), 32'd0);
    chk("rmid_valid",    32'(valid_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
